// File: rtl/sdr_init_seq.sv
// SDRAM power-up sequencer: NOP hold, PRECHARGE ALL, NUM_REF x AUTO REFRESH, LOAD MODE REGISTER.
// Every bus output is a register loaded from the next-state decode, so commands are glitch-free.
module sdr_init_seq #(
  parameter int INIT_WAIT = 10000,
  parameter int TRP       = 3,
  parameter int TRFC      = 7,
  parameter int TMRD      = 2,
  parameter int NUM_REF   = 2
) (
  input  logic        sdram_clk,
  input  logic        sdram_resetn,
  input  logic        cfg_init_req,
  input  logic [12:0] cfg_mode_reg,
  output logic        sdr_cke,
  output logic        sdr_cs_n,
  output logic        sdr_ras_n,
  output logic        sdr_cas_n,
  output logic        sdr_we_n,
  output logic [1:0]  sdr_ba,
  output logic [12:0] sdr_addr,
  output logic        init_busy,
  output logic        init_done
);

  localparam int MAX_A = (INIT_WAIT > TRP) ? INIT_WAIT : TRP;
  localparam int MAX_B = (TRFC > TMRD) ? TRFC : TMRD;
  localparam int MAX_W = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = (MAX_W > 1) ? $clog2(MAX_W + 1) : 1;

  // Wait states are entered only when the interval exceeds one cycle, so the
  // load values below are clamped to stay non-negative for interval = 1.
  localparam logic [CW-1:0] IW_LD   = CW'(INIT_WAIT - 1);
  localparam logic [CW-1:0] TRP_LD  = CW'((TRP  > 1) ? TRP  - 2 : 0);
  localparam logic [CW-1:0] TRFC_LD = CW'((TRFC > 1) ? TRFC - 2 : 0);
  localparam logic [CW-1:0] TMRD_LD = CW'((TMRD > 1) ? TMRD - 2 : 0);

  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_AREF  = 4'b0001;
  localparam logic [3:0] CMD_LMR   = 4'b0000;

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_PWR, S_PRECH, S_TRP_W, S_AREF, S_TRFC_W, S_LMR, S_TMRD_W, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    ref_q, ref_d;
  logic [12:0]   mode_q, mode_d;

  logic          cke_q, cke_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [12:0]   addr_q, addr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    ref_d   = ref_q;
    mode_d  = mode_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (cfg_init_req) begin
          state_d = S_WAIT_PWR;
          cnt_d   = IW_LD;
          mode_d  = cfg_mode_reg;
        end
      end
      S_WAIT_PWR: begin
        if (cnt_q == '0) state_d = S_PRECH;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_PRECH: begin
        ref_d = 3'(NUM_REF);
        cnt_d = TRP_LD;
        state_d = (TRP > 1) ? S_TRP_W : S_AREF;
      end
      S_TRP_W: begin
        if (cnt_q == '0) state_d = S_AREF;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_AREF: begin
        // ref_q still counts the refresh being issued now.
        ref_d = ref_q - 3'd1;
        cnt_d = TRFC_LD;
        if (TRFC > 1)            state_d = S_TRFC_W;
        else if (ref_q == 3'd1)  state_d = S_LMR;
        else                     state_d = S_AREF;
      end
      S_TRFC_W: begin
        if (cnt_q == '0) state_d = (ref_q == 3'd0) ? S_LMR : S_AREF;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_LMR: begin
        cnt_d   = TMRD_LD;
        state_d = (TMRD > 1) ? S_TMRD_W : S_DONE;
      end
      S_TMRD_W: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode looks at the upcoming state so the registered bus lines up with it.
  always_comb begin
    cke_d  = (state_d != S_IDLE);
    cmd_d  = CMD_NOP;
    addr_d = '0;
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
    unique case (state_d)
      S_IDLE:  cmd_d = CMD_DESEL;
      S_PRECH: begin cmd_d = CMD_PRE; addr_d = 13'h400; end
      S_AREF:  cmd_d = CMD_AREF;
      S_LMR:   begin cmd_d = CMD_LMR; addr_d = mode_d; end
      default: cmd_d = CMD_NOP;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ref_q   <= '0;
      mode_q  <= '0;
      cke_q   <= 1'b0;
      cmd_q   <= CMD_DESEL;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ref_q   <= ref_d;
      mode_q  <= mode_d;
      cke_q   <= cke_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sdr_cke   = cke_q;
  assign sdr_cs_n  = cmd_q[3];
  assign sdr_ras_n = cmd_q[2];
  assign sdr_cas_n = cmd_q[1];
  assign sdr_we_n  = cmd_q[0];
  assign sdr_ba    = 2'b00;
  assign sdr_addr  = addr_q;
  assign init_busy = busy_q;
  assign init_done = done_q;

endmodule

// File: tb/tb_sdr_init_seq.sv
// Bench for sdr_init_seq: a cycle-count model of the init sequence checked every cycle on two
// parameter sets, plus literal command checks at the cycle numbers of the directed tests.
module tb_sdr_init_seq;

  localparam int A_IW = 8, A_TRP = 2, A_TRFC = 4, A_TMRD = 2, A_NR = 2;
  localparam int B_IW = 8, B_TRP = 1, B_TRFC = 1, B_TMRD = 1, B_NR = 1;
  localparam int A_TDONE = A_IW + 1 + A_TRP + A_NR * A_TRFC + A_TMRD;
  localparam int B_TDONE = B_IW + 1 + B_TRP + B_NR * B_TRFC + B_TMRD;

  localparam logic [3:0] DESEL = 4'b1111, NOP = 4'b0111, PRE = 4'b0010,
                         AREF = 4'b0001, LMR = 4'b0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [12:0] mode;

  logic        cke_a, cs_a, ras_a, cas_a, we_a, busy_a, done_a;
  logic [1:0]  ba_a;
  logic [12:0] addr_a;
  logic        cke_b, cs_b, ras_b, cas_b, we_b, busy_b, done_b;
  logic [1:0]  ba_b;
  logic [12:0] addr_b;

  int n_cmp = 0;
  int n_err = 0;
  int cur   = 0;

  always #5 clk = ~clk;

  sdr_init_seq #(.INIT_WAIT(A_IW), .TRP(A_TRP), .TRFC(A_TRFC), .TMRD(A_TMRD), .NUM_REF(A_NR)) dut_a (
    .sdram_clk(clk), .sdram_resetn(rst_n), .cfg_init_req(req), .cfg_mode_reg(mode),
    .sdr_cke(cke_a), .sdr_cs_n(cs_a), .sdr_ras_n(ras_a), .sdr_cas_n(cas_a), .sdr_we_n(we_a),
    .sdr_ba(ba_a), .sdr_addr(addr_a), .init_busy(busy_a), .init_done(done_a)
  );

  sdr_init_seq #(.INIT_WAIT(B_IW), .TRP(B_TRP), .TRFC(B_TRFC), .TMRD(B_TMRD), .NUM_REF(B_NR)) dut_b (
    .sdram_clk(clk), .sdram_resetn(rst_n), .cfg_init_req(req), .cfg_mode_reg(mode),
    .sdr_cke(cke_b), .sdr_cs_n(cs_b), .sdr_ras_n(ras_b), .sdr_cas_n(cas_b), .sdr_we_n(we_b),
    .sdr_ba(ba_b), .sdr_addr(addr_b), .init_busy(busy_b), .init_done(done_b)
  );

  logic [21:0] out_a, out_b;
  assign out_a = {cke_a, cs_a, ras_a, cas_a, we_a, ba_a, addr_a, busy_a, done_a};
  assign out_b = {cke_b, cs_b, ras_b, cas_b, we_b, ba_b, addr_b, busy_b, done_b};

  function automatic logic [21:0] mk(input logic cke, input logic [3:0] cmd,
                                     input logic [12:0] addr, input logic busy, input logic done);
    return {cke, cmd, 2'b00, addr, busy, done};
  endfunction

  // Expected bus for t cycles after the accepted start (t = 0: never started or reset).
  function automatic logic [21:0] exp_out(input int t, input logic [12:0] m, input int iw,
                                          input int trp, input int trfc, input int tmrd, input int nr);
    int t_pre, t_ar, t_lmr, t_done;
    t_pre  = iw + 1;
    t_ar   = t_pre + trp;
    t_lmr  = t_ar + nr * trfc;
    t_done = t_lmr + tmrd;
    if (t == 0)                                         return mk(1'b0, DESEL, 13'h0, 1'b0, 1'b0);
    if (t >= t_done)                                    return mk(1'b1, NOP, 13'h0, 1'b0, 1'b1);
    if (t == t_pre)                                     return mk(1'b1, PRE, 13'h400, 1'b1, 1'b0);
    if (t >= t_ar && t < t_lmr && (t - t_ar) % trfc == 0) return mk(1'b1, AREF, 13'h0, 1'b1, 1'b0);
    if (t == t_lmr)                                     return mk(1'b1, LMR, m, 1'b1, 1'b0);
    return mk(1'b1, NOP, 13'h0, 1'b1, 1'b0);
  endfunction

  function automatic int next_t(input int t, input int tdone, input logic r);
    if ((t == 0 || t >= tdone) && r) return 1;
    if (t == 0)                      return 0;
    if (t >= tdone)                  return tdone;
    return t + 1;
  endfunction

  task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: cycles elapsed since each DUT accepted its start, and the latched mode.
  int          t_a = 0, t_b = 0;
  logic [12:0] m_a = '0, m_b = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_a <= 0;
      t_b <= 0;
    end else begin
      if ((t_a == 0 || t_a >= A_TDONE) && req) m_a <= mode;
      if ((t_b == 0 || t_b >= B_TDONE) && req) m_b <= mode;
      t_a <= next_t(t_a, A_TDONE, req);
      t_b <= next_t(t_b, B_TDONE, req);
    end
  end

  always @(negedge clk) begin
    check("model_a", out_a, exp_out(t_a, m_a, A_IW, A_TRP, A_TRFC, A_TMRD, A_NR));
    check("model_b", out_b, exp_out(t_b, m_b, B_IW, B_TRP, B_TRFC, B_TMRD, B_NR));
  end

  // Leaves the bench at the falling edge in the middle of cycle c.
  task automatic wait_cyc(input int c);
    while (cur < c) begin
      @(negedge clk);
      cur++;
    end
  endtask

  task automatic start(input logic [12:0] m);
    @(negedge clk);
    req  = 1'b1;
    mode = m;
    cur  = 0;
    wait_cyc(1);
    req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    req   = 1'b0;
    mode  = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // Test 1: idle after reset.
    repeat (50) @(negedge clk);
    check("t1_idle_a", out_a, mk(1'b0, DESEL, 13'h0, 1'b0, 1'b0));

    // Test 2: nominal sequence on both parameter sets.
    start(13'h033);
    check("t2_c1_a", out_a, mk(1'b1, NOP, 13'h0, 1'b1, 1'b0));
    wait_cyc(8);  check("t2_c8_a", out_a, mk(1'b1, NOP, 13'h0, 1'b1, 1'b0));
    wait_cyc(9);  check("t2_pre_a", out_a, mk(1'b1, PRE, 13'h400, 1'b1, 1'b0));
                  check("t2_pre_b", out_b, mk(1'b1, PRE, 13'h400, 1'b1, 1'b0));
    wait_cyc(10); check("t2_trp_a", out_a, mk(1'b1, NOP, 13'h0, 1'b1, 1'b0));
                  check("t2_aref_b", out_b, mk(1'b1, AREF, 13'h0, 1'b1, 1'b0));
    wait_cyc(11); check("t2_aref1_a", out_a, mk(1'b1, AREF, 13'h0, 1'b1, 1'b0));
                  check("t2_lmr_b", out_b, mk(1'b1, LMR, 13'h033, 1'b1, 1'b0));
    wait_cyc(12); check("t2_done_b", out_b, mk(1'b1, NOP, 13'h0, 1'b0, 1'b1));
    wait_cyc(15); check("t2_aref2_a", out_a, mk(1'b1, AREF, 13'h0, 1'b1, 1'b0));
    wait_cyc(19); check("t2_lmr_a", out_a, mk(1'b1, LMR, 13'h033, 1'b1, 1'b0));
    wait_cyc(20); check("t2_tmrd_a", out_a, mk(1'b1, NOP, 13'h0, 1'b1, 1'b0));
    for (int c = 21; c < 29; c++) begin
      wait_cyc(c);
      check("t2_done_a", out_a, mk(1'b1, NOP, 13'h0, 1'b0, 1'b1));
    end

    // Test 3: start pulses and a mode change while busy must not disturb A.
    start(13'h033);
    wait_cyc(5);  req = 1'b1; mode = 13'h1ff;
    wait_cyc(6);  req = 1'b0;
    wait_cyc(9);  check("t3_pre_a", out_a, mk(1'b1, PRE, 13'h400, 1'b1, 1'b0));
    wait_cyc(12); req = 1'b1;
    wait_cyc(13); req = 1'b0;
    wait_cyc(19); check("t3_lmr_a", out_a, mk(1'b1, LMR, 13'h033, 1'b1, 1'b0));
    wait_cyc(21); check("t3_done_a", out_a, mk(1'b1, NOP, 13'h0, 1'b0, 1'b1));
    wait_cyc(30);

    // Test 4: re-init from DONE with a new mode value.
    start(13'h022);
    check("t4_c1_a", out_a, mk(1'b1, NOP, 13'h0, 1'b1, 1'b0));
    wait_cyc(19); check("t4_lmr_a", out_a, mk(1'b1, LMR, 13'h022, 1'b1, 1'b0));
    wait_cyc(21); check("t4_done_a", out_a, mk(1'b1, NOP, 13'h0, 1'b0, 1'b1));
    wait_cyc(25);

    // Test 5: asynchronous reset in the middle of a refresh wait.
    start(13'h077);
    wait_cyc(13);
    #2 rst_n = 1'b0;
    #1 check("t5_rst_a", out_a, mk(1'b0, DESEL, 13'h0, 1'b0, 1'b0));
       check("t5_rst_b", out_b, mk(1'b0, DESEL, 13'h0, 1'b0, 1'b0));
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    start(13'h011);
    wait_cyc(8);  check("t5_c8_a", out_a, mk(1'b1, NOP, 13'h0, 1'b1, 1'b0));
    wait_cyc(9);  check("t5_pre_a", out_a, mk(1'b1, PRE, 13'h400, 1'b1, 1'b0));
    wait_cyc(11); check("t5_lmr_b", out_b, mk(1'b1, LMR, 13'h011, 1'b1, 1'b0));
    wait_cyc(25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
